// File: rtl/accum_sat_pkg.sv
// accum_sat_pkg: shared number/state types and saturation limits for accumulator stages
package accum_sat_pkg;
  typedef enum logic {UNSIGNED, SIGNED} num_t;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} acc_state_t;
  function automatic logic [63:0] max_val(input int dwd, input num_t t);
    return t == SIGNED ? ~64'd0 >> (65 - dwd) : ~64'd0 >> (64 - dwd);
  endfunction
  function automatic logic [63:0] min_val(input int dwd, input num_t t);
    return t == SIGNED ? 64'd1 << (dwd - 1) : 64'd0;
  endfunction
endpackage

// File: rtl/accum_sat_if.sv
// accum_sat_if: operand stream in, saturated result stream out
interface accum_sat_if #(
  parameter int DWd   = 8,
  parameter int LenWd = 8
);
  logic             i_clr;
  logic [LenWd-1:0] i_len;
  logic             i_valid;
  logic             i_ready;
  logic [DWd-1:0]   i_data;
  logic             o_valid;
  logic             o_ready;
  logic [DWd-1:0]   o_data;
  logic             o_ovf;
  logic             o_udf;
  modport master (output i_clr, i_len, i_valid, i_data, o_ready,
                  input  i_ready, o_valid, o_data, o_ovf, o_udf);
  modport slave  (input  i_clr, i_len, i_valid, i_data, o_ready,
                  output i_ready, o_valid, o_data, o_ovf, o_udf);
endinterface

// File: rtl/accum_sat_sat_add.sv
// sat_add: one-step clamping adder on a DWd+1-bit extended sum
module sat_add import accum_sat_pkg::*; #(
  parameter int   DWd  = 8,
  parameter num_t Type = UNSIGNED
) (
  input  logic [DWd-1:0] a,
  input  logic [DWd-1:0] b,
  output logic [DWd-1:0] sum,
  output logic           ovf,
  output logic           udf
);
  localparam logic [DWd-1:0] MaxV = DWd'(max_val(DWd, Type));
  localparam logic [DWd-1:0] MinV = DWd'(min_val(DWd, Type));
  logic [DWd:0] s;
  assign s   = {Type == SIGNED && a[DWd-1], a} + {Type == SIGNED && b[DWd-1], b};
  assign ovf = Type == SIGNED ? s[DWd -: 2] == 2'b01 : s[DWd];
  assign udf = Type == SIGNED && s[DWd -: 2] == 2'b10;
  assign sum = ovf ? MaxV : udf ? MinV : s[DWd-1:0];
endmodule

// File: rtl/accum_sat.sv
// accum_sat: sums frames of i_len+1 operands with per-add saturation; result held until o_ready
module accum_sat import accum_sat_pkg::*; #(
  parameter int   DWd   = 8,
  parameter num_t Type  = UNSIGNED,
  parameter int   LenWd = 8
) (
  input logic        clk,
  input logic        rst_n,
  accum_sat_if.slave bus
);
  acc_state_t       state_q, state_d;
  logic [DWd-1:0]   acc_q, acc_d, sum;
  logic [LenWd-1:0] cnt_q, cnt_d, len_q, len_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, add_ovf, add_udf, take;
  sat_add #(.DWd(DWd), .Type(Type)) u_add (
    .a(acc_q), .b(bus.i_data), .sum(sum), .ovf(add_ovf), .udf(add_udf)
  );
  assign take        = bus.i_valid && state_q != HOLD;
  assign bus.i_ready = state_q != HOLD;
  assign bus.o_valid = state_q == HOLD;
  assign bus.o_data  = acc_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_udf   = udf_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (bus.i_clr) begin
      state_d = IDLE;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (state_q == IDLE && take) begin
      acc_d   = bus.i_data;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      len_d   = bus.i_len;
      cnt_d   = '0;
      state_d = bus.i_len == '0 ? HOLD : ACC;
    end else if (state_q == ACC && take) begin
      acc_d   = sum;
      ovf_d   = ovf_q | add_ovf;
      udf_d   = udf_q | add_udf;
      cnt_d   = cnt_q + LenWd'(1);
      // len_q >= 1 here, so len_q-1 never wraps and cnt tops out below 2**LenWd-1
      state_d = cnt_q == len_q - LenWd'(1) ? HOLD : ACC;
    end else if (state_q == HOLD && bus.o_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end
endmodule
